// File: rtl/exe_muldiv_sequencer.sv
// exe_muldiv_sequencer
//   Multi-cycle RV32M multiply/divide sequencer living beside the EXE-stage ALU.
//   Multiplies with a radix-2 shift-add loop and divides with a restoring loop,
//   one bit per clock over XLEN iterations, then applies sign correction.
//   Divide-by-zero and signed-overflow divides bypass the loop and finish at once.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous reset, active low
//   start   EXE holds an M-extension instruction (held until done)
//   flush   synchronous abort; overrides everything
//   op      funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   dataA   rs1 operand, sampled only on accept
//   dataB   rs2 operand, sampled only on accept
//   result  registered result, valid while done=1
//   done    one-cycle result-valid pulse
//   busy    sequencer not idle
//   stall   freezes the IF/ID/EXE pipeline registers
module exe_muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] dataA,
    input  logic [XLEN-1:0] dataB,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            stall
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateT;

    stateT             state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        opQ;
    logic              negAQ;
    logic              negBQ;
    // accHi:accLo is the product register during multiply and the
    // remainder:quotient pair during divide; opnd holds multiplicand/divisor.
    logic [XLEN-1:0]   accHi;
    logic [XLEN-1:0]   accLo;
    logic [XLEN-1:0]   opnd;
    logic              doneQ;

    function automatic logic [XLEN-1:0] negX(input logic [XLEN-1:0] v);
        return '0 - v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg2X(input logic [2*XLEN-1:0] v);
        return '0 - v;
    endfunction

    // Operand decode on accept
    logic            aSigned, bSigned, negA, negB, isDiv, divZero, divOvf;
    logic [XLEN-1:0] magA, magB, specialRes;

    always_comb begin
        isDiv   = op[2];
        aSigned = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        bSigned = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        negA    = aSigned && dataA[XLEN-1];
        negB    = bSigned && dataB[XLEN-1];
        magA    = negA ? negX(dataA) : dataA;
        magB    = negB ? negX(dataB) : dataB;
        divZero = isDiv && (dataB == '0);
        // Only signed DIV/REM (op[0]=0) can overflow: most-negative / -1.
        divOvf  = isDiv && !op[0] && (dataA == {1'b1, {(XLEN-1){1'b0}}}) && (dataB == '1);
        if (divZero)
            specialRes = op[1] ? dataA : '1;
        else
            specialRes = op[1] ? '0 : dataA;
    end

    // One iteration step
    logic [XLEN:0]   mulAdd;
    logic [XLEN:0]   shifted;
    logic            divOk;
    logic [XLEN-1:0] remNext;

    always_comb begin
        mulAdd  = accLo[0] ? ({1'b0, accHi} + {1'b0, opnd}) : {1'b0, accHi};
        shifted = {accHi, accLo[XLEN-1]};
        divOk   = (shifted >= {1'b0, opnd});
        // When the trial succeeds the true difference is below the divisor,
        // so the low XLEN bits are exact.
        remNext = shifted[XLEN-1:0] - opnd;
    end

    // Sign correction and final select
    logic [2*XLEN-1:0] prodFix;
    logic [XLEN-1:0]   quoFix, remFix, fixSel;

    always_comb begin
        prodFix = (negAQ ^ negBQ) ? neg2X({accHi, accLo}) : {accHi, accLo};
        quoFix  = (negAQ ^ negBQ) ? negX(accLo) : accLo;
        remFix  = negAQ ? negX(accHi) : accHi;
        case (opQ)
            3'd0:                fixSel = prodFix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fixSel = prodFix[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fixSel = quoFix;
            default:             fixSel = remFix;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            opQ    <= '0;
            negAQ  <= 1'b0;
            negBQ  <= 1'b0;
            accHi  <= '0;
            accLo  <= '0;
            opnd   <= '0;
            result <= '0;
            doneQ  <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            opQ   <= op;
                            negAQ <= negA;
                            negBQ <= negB;
                            cnt   <= CNT_W'(XLEN);
                            accHi <= '0;
                            accLo <= magA;
                            opnd  <= magB;
                            if (divZero || divOvf) begin
                                result <= specialRes;
                                doneQ  <= 1'b1;
                                state  <= DONE;
                            end else begin
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        if (opQ[2]) begin
                            accHi <= divOk ? remNext : shifted[XLEN-1:0];
                            accLo <= {accLo[XLEN-2:0], divOk};
                        end else begin
                            accHi <= mulAdd[XLEN:1];
                            accLo <= {mulAdd[0], accLo[XLEN-1:1]};
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1))
                            state <= FIX;
                    end
                    FIX: begin
                        result <= fixSel;
                        doneQ  <= 1'b1;
                        state  <= DONE;
                    end
                    // start is still the finished instruction here; ignore it.
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy  = (state != IDLE);
    assign done  = doneQ && !flush;
    // Gated by rst so that asserting reset drops stall even while start is held.
    assign stall = rst && !flush &&
                   (((state == IDLE) && start) || (state == CALC) || (state == FIX));

endmodule
